// File: rtl/stream_result_mux.sv
// -----------------------------------------------------------------------------
// stream_result_mux
//
// N-channel result selector between the ALU operation units and the
// result/writeback stage. The output stage is fully registered and uses a
// valid/ready handshake on both sides.
//
// Modes (sampled on accept only):
//   single (in_mode=0) : one output beat carrying channel in_sel, marked last.
//   scan   (in_mode=1) : the input word is snapshotted and all N channels are
//                        emitted in rotating order starting at in_sel. Only
//                        the N-th beat is marked last.
//
// Parameters:
//   WIDTH  bit width of each channel and of out_data (>=1)
//   SEL_W  select width; channel count N = 2**SEL_W (>=2 channels)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream beat present
//   in_ready   block can accept a beat this cycle (combinational)
//   in_data    packed channels, channel k = in_data[k*WIDTH +: WIDTH]
//   in_sel     channel select (single) or start channel (scan)
//   in_mode    0 = single, 1 = scan
//   out_valid  out_* hold a beat
//   out_ready  downstream accepts the beat
//   out_data   selected channel value
//   out_ch     channel index of out_data
//   out_zero   out_data == 0
//   out_last   final beat of the current transaction
// -----------------------------------------------------------------------------
module stream_result_mux #(
    parameter int WIDTH = 4,
    parameter int SEL_W = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [(1 << SEL_W)*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]              in_sel,
    input  logic                          in_mode,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [SEL_W-1:0]              out_ch,
    output logic                          out_zero,
    output logic                          out_last
);

    localparam int N = 1 << SEL_W;

    // FSM encoding
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    // Counter value of the final scan beat (N-1 is all ones in SEL_W bits)
    localparam logic [SEL_W-1:0] CNT_LAST = {SEL_W{1'b1}};
    localparam logic [SEL_W-1:0] CNT_ONE  = SEL_W'(1'b1);

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Extract channel idx from a packed N-channel word.
    function automatic logic [WIDTH-1:0] pick_channel(
        input logic [N*WIDTH-1:0] data,
        input logic [SEL_W-1:0]   idx
    );
        pick_channel = data[int'(idx)*WIDTH +: WIDTH];
    endfunction

    // Zero flag for a channel value.
    function automatic logic is_zero(input logic [WIDTH-1:0] value);
        is_zero = (value == {WIDTH{1'b0}});
    endfunction

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    logic [0:0]         state_r;
    logic [N*WIDTH-1:0] snap_r;
    logic [SEL_W-1:0]   start_r;
    logic [SEL_W-1:0]   cnt_r;
    logic               out_valid_r;
    logic [WIDTH-1:0]   out_data_r;
    logic [SEL_W-1:0]   out_ch_r;
    logic               out_zero_r;
    logic               out_last_r;

    // Next-state values
    logic [0:0]         state_s;
    logic [N*WIDTH-1:0] snap_s;
    logic [SEL_W-1:0]   start_s;
    logic [SEL_W-1:0]   cnt_s;
    logic               valid_s;
    logic [WIDTH-1:0]   data_s;
    logic [SEL_W-1:0]   ch_s;
    logic               zero_s;
    logic               last_s;

    // Handshake qualifiers
    logic               in_ready_s;
    logic               accept_s;
    logic               xfer_s;
    logic [SEL_W-1:0]   scan_ch_s;

    // Upstream may only enter while idle and the output slot is free or
    // draining this cycle; this keeps full-rate single beats possible.
    always_comb begin
        in_ready_s = (state_r == IDLE) && (!out_valid_r || out_ready);
        accept_s   = in_valid && in_ready_s;
        xfer_s     = out_valid_r && out_ready;
        // Natural SEL_W-bit wrap gives the modulo-N rotation.
        scan_ch_s  = start_r + cnt_r;
    end

    // Next-state and next-output computation for the IDLE/SCAN controller.
    always_comb begin
        state_s = state_r;
        snap_s  = snap_r;
        start_s = start_r;
        cnt_s   = cnt_r;
        valid_s = out_valid_r;
        data_s  = out_data_r;
        ch_s    = out_ch_r;
        last_s  = out_last_r;

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    valid_s = 1'b1;
                    data_s  = pick_channel(in_data, in_sel);
                    ch_s    = in_sel;
                    if (in_mode) begin
                        // First scan beat goes out now; the rest come from
                        // the snapshot so upstream changes cannot leak in.
                        last_s  = 1'b0;
                        snap_s  = in_data;
                        start_s = in_sel;
                        cnt_s   = CNT_ONE;
                        state_s = SCAN;
                    end else begin
                        last_s  = 1'b1;
                    end
                end else if (xfer_s) begin
                    valid_s = 1'b0;
                end else begin
                    valid_s = out_valid_r;
                end
            end

            SCAN: begin
                if (xfer_s) begin
                    valid_s = 1'b1;
                    data_s  = pick_channel(snap_r, scan_ch_s);
                    ch_s    = scan_ch_s;
                    cnt_s   = cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        last_s  = 1'b1;
                        state_s = IDLE;
                    end else begin
                        last_s  = 1'b0;
                    end
                end else begin
                    state_s = SCAN;
                end
            end

            default: begin
                // Unreachable encoding: recover to a quiet idle state.
                state_s = IDLE;
                valid_s = 1'b0;
                cnt_s   = {SEL_W{1'b0}};
            end
        endcase

        // Flag tracks the data register exactly, including while holding.
        zero_s = is_zero(data_s);
    end

    // Controller, snapshot and registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            snap_r      <= {(N*WIDTH){1'b0}};
            start_r     <= {SEL_W{1'b0}};
            cnt_r       <= {SEL_W{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            out_ch_r    <= {SEL_W{1'b0}};
            out_zero_r  <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            snap_r      <= snap_s;
            start_r     <= start_s;
            cnt_r       <= cnt_s;
            out_valid_r <= valid_s;
            out_data_r  <= data_s;
            out_ch_r    <= ch_s;
            out_zero_r  <= zero_s;
            out_last_r  <= last_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_ch    = out_ch_r;
    assign out_zero  = out_zero_r;
    assign out_last  = out_last_r;

endmodule

// File: doc/stream_result_mux.md
Name: stream_result_mux

Overview:
Parametrised N-channel, WIDTH-bit result selector for the ALU datapath, with a registered output and a valid/ready handshake on both sides.
- Single mode: each accepted beat forwards one selected channel.
- Scan mode: each accepted beat is snapshotted, then all N channels are emitted in rotating order starting at the selected channel.
- Sits between the ALU operation units and the result/writeback stage.

Parameters:
WIDTH, 4, bit width of each channel and of out_data (>=1)
SEL_W, 3, select width; channel count N = 2**SEL_W (SEL_W>=1, so N>=2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream beat present
in_ready  output  1  block can accept a beat this cycle
in_data  input  N*WIDTH  packed channels; channel k = in_data[k*WIDTH +: WIDTH]
in_sel  input  SEL_W  channel select (single mode) or start channel (scan mode)
in_mode  input  1  0 = single, 1 = scan; sampled only on accept
out_valid  output  1  out_* hold a beat
out_ready  input  1  downstream accepts the beat
out_data  output  WIDTH  selected channel value
out_ch  output  SEL_W  channel index of out_data
out_zero  output  1  out_data == 0
out_last  output  1  final beat of the current transaction

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid, out_data, out_ch, out_zero, out_last all go to 0.
  - FSM goes to IDLE; scan counter and snapshot are cleared.
  - in_ready = 1 from the first cycle after reset release.
- Handshake:
  - accept = in_valid & in_ready.
  - A downstream transfer occurs when out_valid & out_ready.
  - All out_* are registered and stay stable while out_valid=1 and out_ready=0.
- in_ready (combinational) = (state==IDLE) & (!out_valid | out_ready). Full-rate back-to-back single beats are supported.
- FSM states: IDLE, SCAN.
- IDLE, accept with in_mode=0:
  - Next edge: out_data<=channel in_sel, out_ch<=in_sel, out_last<=1, out_valid<=1. Latency is 1 cycle.
  - State stays IDLE.
- IDLE, accept with in_mode=1:
  - snapshot<=in_data; first beat loads channel in_sel with out_last<=0.
  - start<=in_sel, cnt<=1, state<=SCAN.
- IDLE, no accept, downstream transfer: out_valid<=0.
- SCAN:
  - in_ready=0. On each downstream transfer, load channel (start+cnt) mod N from the snapshot, then cnt<=cnt+1.
  - out_last<=1 when the loaded beat is the N-th (cnt==N-1); on that same edge state<=IDLE.
  - Without out_ready, everything holds.
  - Changes on in_data, in_sel or in_mode during SCAN have no effect.
- Channel index arithmetic is modulo N: natural SEL_W-bit wrap, e.g. start=6, N=8 gives 6,7,0,...,5.
- out_zero is registered together with out_data; it reflects exactly the loaded value.
- A scan emits exactly N beats, with exactly one out_last; a single-mode beat is always last.
- Reset asserted mid-scan: the scan is aborted immediately. Remaining beats are never emitted, and after release the block is in IDLE with out_valid=0.
- in_valid with in_ready=0: no state change. Upstream holds the beat.

Test Plan:
1. WIDTH=4, SEL_W=3, in_data=32'h76543210, single, in_sel=5, out_ready=1 -> next cycle out_valid=1, out_data=5, out_ch=5, out_zero=0, out_last=1.
2. Single beats on consecutive cycles with sel=0,3,7, out_ready=1 -> outputs 0,3,7 on consecutive cycles; out_zero=1 only for sel=0; in_ready stays 1.
3. Single beat sel=2 with out_ready=0 for 3 cycles -> out_data=2 held stable, in_ready=0; a second pending beat sel=4 is accepted on the cycle out_ready rises and appears 1 cycle later.
4. Scan, in_sel=6, out_ready=1 -> 8 beats with out_ch=6,7,0,1,2,3,4,5 and out_data equal to out_ch. out_last=1 only on ch5; in_ready=0 until that beat is transferred. Changing in_data to all 0xF mid-scan does not alter any output.
5. Scan, in_sel=0, with out_ready toggling 1,0,1,0 -> each beat held while out_ready=0; no beat is skipped or duplicated; 8 total.
6. Scan in progress, rst_n pulsed low between clock edges on the 3rd beat -> out_valid=0 immediately. After release, in_ready=1; a single beat sel=1 yields out_data=1, out_last=1.
